ps2_txfuncmod: RTL and testbench
================================

PS2_TXFUNCMOD -- requirements
Module: ps2_txfuncmod

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter INHIBIT_US, default 100, host clock-inhibit duration in microseconds.
REQ-003 SHALL have parameter TIMEOUT_US, default 15_000, maximum wait for device activity per phase, in microseconds.
REQ-004 CLOCK  input  1  system clock; single clock domain; all logic on rising edge.
REQ-005 RST  input  1  reset, asynchronous and active-high.
REQ-006 iCall  input  1  one-cycle request to transmit iData; honoured only in IDLE.
REQ-007 iData  input  8  command byte, captured on accepted iCall.
REQ-008 oDone  output  1  one-cycle pulse at end of every accepted transfer, success or failure.
REQ-009 oErr  output  1  valid with oDone: 1 = timeout or missing ACK, 0 = ACK received.
REQ-010 oBusy  output  1  high from accepted iCall through the oDone cycle.
REQ-011 PS2_CLK_I  input  1  sensed PS/2 clock line (asynchronous).
REQ-012 PS2_DAT_I  input  1  sensed PS/2 data line (asynchronous).
REQ-013 PS2_CLK_OE  output  1  1 = pull PS/2 clock line low; 0 = release.
REQ-014 PS2_DAT_OE  output  1  1 = pull PS/2 data line low; 0 = release.

Function
REQ-015 PS2_CLK_I and PS2_DAT_I SHALL pass through a 2-flop synchronizer; a device falling edge is sync-clock 1→0 and is seen 3 cycles after the pin change.
REQ-016 States SHALL be IDLE, INHIBIT, REQ, BITS, STOP, ACK, WAIT_IDLE, DONE.
REQ-017 IDLE: both OE=0, oBusy=0; iCall captures {odd parity, iData} into an internal frame, clears bit counter and timer, goes to INHIBIT next cycle.
REQ-018 INHIBIT: PS2_CLK_OE=1 for exactly CLK_FREQ/1_000_000*INHIBIT_US cycles (5000 at defaults); PS2_DAT_OE asserts in the last cycle; then REQ.
REQ-019 REQ: PS2_CLK_OE=0, PS2_DAT_OE=1 (start bit 0); the first device falling edge drives frame bit 0 and moves to BITS.
REQ-020 BITS: each device falling edge SHALL shift the next frame bit out (D0..D7 LSB first, then parity), PS2_DAT_OE = NOT current bit; after the parity bit is presented, the next falling edge moves to STOP.
REQ-021 Parity SHALL be odd: parity bit = NOT(XOR of iData); e.g. 8'hED → parity 1, 8'h00 → parity 1, 8'h01 → parity 0.
REQ-022 STOP: PS2_DAT_OE=0 (stop bit 1); the next falling edge samples synced data: 0 → ACK ok, 1 → error; both go to ACK/WAIT_IDLE path (ACK state records result).
REQ-023 WAIT_IDLE: waits until synced clock and data are both 1, then DONE.
REQ-024 DONE: oDone=1 and oErr=recorded result for one cycle, then IDLE.
REQ-025 Timeout: in REQ, BITS, STOP, ACK and WAIT_IDLE a timer counts cycles since the last falling edge (or state entry); reaching CLK_FREQ/1_000_000*TIMEOUT_US (750_000 at defaults) SHALL release both OE, set error, go to DONE.
REQ-026 iCall while oBusy=1 SHALL be ignored, with no effect on the transfer in progress or the captured byte.
REQ-027 Device falling edges in IDLE, INHIBIT, WAIT_IDLE or DONE SHALL be ignored.
REQ-028 OE outputs SHALL be registered (glitch-free); at most one of them changes per state transition except entering DONE on error.

Reset
REQ-029 RST=1 SHALL immediately force IDLE, PS2_CLK_OE=0, PS2_DAT_OE=0, oDone=0, oErr=0, oBusy=0, clear frame, counters and synchronizers to 1 (idle lines).
REQ-030 RST asserted mid-transfer SHALL release both lines with no oDone pulse; the first transfer after release starts only on a new iCall.

Structure
REQ-031 State encoding, parity function and timing-count derivation SHALL reside in shared package ps2_pkg, also used by the receiver.
REQ-032 Synchronizer plus falling-edge detector SHALL be sub-module ps2_sync_edge, instantiated once per line and reusable by the receiver.

Verification
REQ-033 iCall with iData=8'hED, device model clocks 11 periods at 12.5 kHz and ACKs → line shows start 0, 1,0,1,1,0,1,1,1, parity 1, stop 1; oDone with oErr=0.
REQ-034 iData=8'hF4, device omits ACK (data high at 11th edge) → oDone, oErr=1, both OE=0 afterwards.
REQ-035 iCall, device never clocks → at 750_000 cycles after REQ entry both OE released, oDone with oErr=1.
REQ-036 RST pulse after 4th data bit → both OE=0 in the same cycle, no oDone; next iCall with 8'h00 completes, parity bit 1, oErr=0.
REQ-037 Second iCall pulsed during BITS with iData=8'hFF → ignored; transmitted byte remains the first one; exactly one oDone.
REQ-038 INHIBIT check: PS2_CLK_OE high for exactly 5000 cycles, PS2_DAT_OE rises on cycle 5000.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame layout, parity and timing helpers.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package ps2_pkg;

    // Host-to-device transmitter states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_BITS,
        ST_STOP,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_DONE
    } ps2_state_e;

    // Frame shifted onto the data line after the start bit: 8 data bits LSB first, then parity
    localparam int unsigned FRAME_BITS = 9;
    typedef logic [FRAME_BITS-1:0] ps2_frame_t;

    // Odd parity: the nine frame bits together always hold an odd number of ones
    function automatic logic odd_parity(input logic [7:0] d);
        return ~(^d);
    endfunction

    // Whole-microsecond durations expressed in system clock cycles
    function automatic int unsigned us_to_cycles(input int unsigned clk_freq, input int unsigned us);
        return (clk_freq / 1_000_000) * us;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one PS/2 line plus a falling-edge detector on the synced value.
// Latency: sync_o follows the pin after 2 cycles; fall_o is high for the one cycle after the synced 1->0.
// Backpressure: none; every edge on the line produces exactly one fall_o pulse.
module ps2_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic sync_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Resynchronise the pin and keep one cycle of history; reset to the idle (high) line level
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_txfuncmod.sv
// PS/2 host-to-device command transmitter: clock inhibit, request-to-send, 8 data + odd parity, stop, device ACK.
// Latency: INHIBIT_US of inhibit, then paced by the device clock; oDone pulses once the lines are idle again.
// Backpressure: iCall is taken only when idle and dropped while busy; every device-paced phase is bounded by TIMEOUT_US.
module ps2_txfuncmod
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned INHIBIT_US = 100,
    parameter int unsigned TIMEOUT_US = 15_000
) (
    input  logic       CLOCK,
    input  logic       RST,
    input  logic       iCall,
    input  logic [7:0] iData,
    output logic       oDone,
    output logic       oErr,
    output logic       oBusy,
    input  logic       PS2_CLK_I,
    input  logic       PS2_DAT_I,
    output logic       PS2_CLK_OE,
    output logic       PS2_DAT_OE
);

    localparam int unsigned INHIBIT_CYC = us_to_cycles(CLK_FREQ, INHIBIT_US);
    localparam int unsigned TIMEOUT_CYC = us_to_cycles(CLK_FREQ, TIMEOUT_US);
    localparam int unsigned MAX_CYC     = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int unsigned TMR_W       = $clog2(MAX_CYC + 1);

    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0] INH_PRE  = TMR_W'(INHIBIT_CYC - 2);
    localparam logic [TMR_W-1:0] INH_LAST = TMR_W'(INHIBIT_CYC - 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]       CNT_LAST = 4'(FRAME_BITS);

    ps2_state_e       state_q;
    ps2_frame_t       frame_q;
    logic [3:0]       bit_cnt_q;
    logic [TMR_W-1:0] timer_q;
    logic             ack_err_q;
    logic             clk_oe_q;
    logic             dat_oe_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic clk_sync;
    logic clk_fall;
    logic dat_sync;
    logic dat_fall_unused;
    logic timed_phase;
    logic timeout;

    ps2_sync_edge u_clk_sync (
        .clk_i  (CLOCK),
        .rst_i  (RST),
        .line_i (PS2_CLK_I),
        .sync_o (clk_sync),
        .fall_o (clk_fall)
    );

    ps2_sync_edge u_dat_sync (
        .clk_i  (CLOCK),
        .rst_i  (RST),
        .line_i (PS2_DAT_I),
        .sync_o (dat_sync),
        .fall_o (dat_fall_unused)
    );

    // Phases that wait on the device are abandoned once the timer runs out
    assign timed_phase = (state_q == ST_REQ) || (state_q == ST_BITS) || (state_q == ST_STOP)
                      || (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);
    assign timeout     = timed_phase && (timer_q == TMO_LAST);

    // Transmit sequencer; all line enables and status outputs are registered here
    always_ff @(posedge CLOCK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            frame_q   <= '0;
            bit_cnt_q <= '0;
            timer_q   <= '0;
            ack_err_q <= 1'b0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (timeout) begin
                // Device went quiet: let go of both lines together and report failure
                clk_oe_q <= 1'b0;
                dat_oe_q <= 1'b0;
                timer_q  <= '0;
                done_q   <= 1'b1;
                err_q    <= 1'b1;
                state_q  <= ST_DONE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (iCall) begin
                            frame_q   <= {odd_parity(iData), iData};
                            bit_cnt_q <= '0;
                            timer_q   <= '0;
                            ack_err_q <= 1'b0;
                            busy_q    <= 1'b1;
                            clk_oe_q  <= 1'b1;
                            state_q   <= ST_INHIBIT;
                        end
                    end
                    ST_INHIBIT: begin
                        // Data goes low one cycle before the clock is released so only one line moves per step
                        timer_q <= timer_q + TMR_ONE;
                        if (timer_q == INH_PRE) begin
                            dat_oe_q <= 1'b1;
                        end
                        if (timer_q == INH_LAST) begin
                            timer_q  <= '0;
                            clk_oe_q <= 1'b0;
                            state_q  <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        timer_q <= timer_q + TMR_ONE;
                        if (clk_fall) begin
                            timer_q   <= '0;
                            dat_oe_q  <= ~frame_q[0];
                            frame_q   <= frame_q >> 1;
                            bit_cnt_q <= 4'd1;
                            state_q   <= ST_BITS;
                        end
                    end
                    ST_BITS: begin
                        timer_q <= timer_q + TMR_ONE;
                        if (clk_fall) begin
                            timer_q <= '0;
                            if (bit_cnt_q == CNT_LAST) begin
                                dat_oe_q <= 1'b0;
                                state_q  <= ST_STOP;
                            end else begin
                                dat_oe_q  <= ~frame_q[0];
                                frame_q   <= frame_q >> 1;
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    ST_STOP: begin
                        timer_q <= timer_q + TMR_ONE;
                        if (clk_fall) begin
                            timer_q <= '0;
                            state_q <= ST_ACK;
                        end
                    end
                    ST_ACK: begin
                        // Device holds its ACK through the low clock phase, so the synced level is still valid
                        ack_err_q <= dat_sync;
                        timer_q   <= '0;
                        state_q   <= ST_WAIT_IDLE;
                    end
                    ST_WAIT_IDLE: begin
                        timer_q <= timer_q + TMR_ONE;
                        if (clk_sync && dat_sync) begin
                            done_q  <= 1'b1;
                            err_q   <= ack_err_q;
                            state_q <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign PS2_CLK_OE = clk_oe_q;
    assign PS2_DAT_OE = dat_oe_q;
    assign oBusy      = busy_q;
    assign oDone      = done_q;
    assign oErr       = err_q;

endmodule

// File: tb/tb_ps2_txfuncmod.sv
// Bench for the PS/2 transmitter: open-collector line model, behavioural device, result scoreboard.
// Latency: scaled timing (5000-cycle inhibit, 3000-cycle timeout, 200-cycle device clock period).
// Backpressure: checks that a second request while busy is dropped.
module tb_ps2_txfuncmod;

    localparam int unsigned CLK_FREQ   = 10_000_000;
    localparam int unsigned INHIBIT_US = 500;
    localparam int unsigned TIMEOUT_US = 300;
    localparam int          INH_CYC    = 5000;
    localparam int          TMO_CYC    = 3000;
    localparam int          HP         = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       call = 1'b0;
    logic [7:0] data = 8'h00;
    logic       done;
    logic       err;
    logic       busy;
    logic       clk_oe;
    logic       dat_oe;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       line_clk;
    logic       line_dat;

    int vec = 0;
    int miss = 0;
    int done_cnt = 0;
    bit exp_err_q[$];

    always #5 clk = ~clk;

    // Wired-AND bus: host pulls low through its enables, device pulls low by driving 0
    assign line_clk = dev_clk & ~clk_oe;
    assign line_dat = dev_dat & ~dat_oe;

    ps2_txfuncmod #(
        .CLK_FREQ   (CLK_FREQ),
        .INHIBIT_US (INHIBIT_US),
        .TIMEOUT_US (TIMEOUT_US)
    ) dut (
        .CLOCK      (clk),
        .RST        (rst),
        .iCall      (call),
        .iData      (data),
        .oDone      (done),
        .oErr       (err),
        .oBusy      (busy),
        .PS2_CLK_I  (line_clk),
        .PS2_DAT_I  (line_dat),
        .PS2_CLK_OE (clk_oe),
        .PS2_DAT_OE (dat_oe)
    );

    // Bits the device should see, index 0 = start, 1..8 = data LSB first, 9 = parity, 10 = stop
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic par;
        par = (($countones(d) % 2) == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic check(input string name, input int act, input int req);
        vec++;
        if (act !== req) begin
            miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Per-cycle compare against the transfer-level model
    always @(negedge clk) begin
        if (!rst) begin
            check("idle_lines_released", int'(!busy && (clk_oe || dat_oe)), 0);
            if (done) begin
                done_cnt++;
                check("done_inside_busy", int'(busy), 1);
                check("done_lines_released", int'({clk_oe, dat_oe}), 0);
                if (exp_err_q.size() == 0) begin
                    vec++;
                    miss++;
                    $display("FAIL unexpected_done: got oDone=1, expected no pending transfer");
                end else begin
                    check("done_err", int'(err), int'(exp_err_q.pop_front()));
                end
            end
        end
    end

    task automatic start_call(input logic [7:0] d);
        @(posedge clk);
        #1 call = 1'b1;
        data = d;
        @(posedge clk);
        #1 call = 1'b0;
    endtask

    // Measures the inhibit window; returns on the first sample after the clock line is released
    task automatic check_inhibit();
        int n = 0;
        int rise = 0;
        int g = 0;
        @(negedge clk);
        while (!clk_oe && g < 100) begin
            @(negedge clk);
            g++;
        end
        while (clk_oe && n < 20000) begin
            n++;
            if (dat_oe && rise == 0) rise = n;
            @(negedge clk);
        end
        check("inhibit_len", n, INH_CYC);
        check("inhibit_dat_rise", rise, INH_CYC);
    endtask

    // Device side: clocks `edges` periods, samples data while clock is high, optionally ACKs
    task automatic device(input bit ack, input int edges, output logic [10:0] seen);
        int g = 0;
        seen = '0;
        while (!(!clk_oe && dat_oe) && g < 20000) begin
            @(negedge clk);
            g++;
        end
        check("request_to_send", int'(!clk_oe && dat_oe), 1);
        seen[0] = line_dat;
        for (int k = 1; k <= edges; k++) begin
            repeat (HP) @(posedge clk);
            #1 dev_clk = 1'b0;
            repeat (HP) @(posedge clk);
            #1 dev_clk = 1'b1;
            @(negedge clk);
            if (k <= 10) seen[k] = line_dat;
            if (k == 10 && ack) dev_dat = 1'b0;
            if (k == 11) dev_dat = 1'b1;
        end
    endtask

    task automatic wait_done(input int d0, input int budget);
        int g = 0;
        while (done_cnt == d0 && g < budget) begin
            @(negedge clk);
            g++;
        end
        check("done_seen", int'(done_cnt != d0), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [10:0] seen;
        int d0;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_clk_oe", int'(clk_oe), 0);
        check("rst_dat_oe", int'(dat_oe), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 0xED with ACK
        d0 = done_cnt;
        exp_err_q.push_back(1'b0);
        start_call(8'hED);
        check_inhibit();
        device(1'b1, 11, seen);
        check("ed_line_literal", int'(seen), int'(11'b11111011010));
        check("ed_line_model", int'(seen), int'(model_frame(8'hED)));
        wait_done(d0, 2000);
        repeat (20) @(negedge clk);

        // 0xF4 without ACK
        d0 = done_cnt;
        exp_err_q.push_back(1'b1);
        start_call(8'hF4);
        check_inhibit();
        device(1'b0, 11, seen);
        check("f4_line_literal", int'(seen), int'(11'b10111101000));
        wait_done(d0, 2000);
        repeat (5) @(negedge clk);
        check("f4_lines_after", int'({clk_oe, dat_oe}), 0);

        // Device never clocks
        d0 = done_cnt;
        exp_err_q.push_back(1'b1);
        start_call(8'hA5);
        check_inhibit();
        n = 0;
        while (dat_oe && n < 10000) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", n, TMO_CYC);
        check("timeout_done", int'(done), 1);
        check("timeout_lines", int'({clk_oe, dat_oe}), 0);
        wait_done(d0, 10);
        repeat (20) @(negedge clk);

        // Reset after the 4th data bit
        d0 = done_cnt;
        start_call(8'h96);
        check_inhibit();
        device(1'b1, 4, seen);
        check("abort_prefix", int'(seen & 11'h01F), int'(model_frame(8'h96) & 11'h01F));
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_clk_oe", int'(clk_oe), 0);
        check("rst_mid_dat_oe", int'(dat_oe), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_done", int'(done), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("no_restart_busy", int'(busy), 0);
        check("no_restart_clk_oe", int'(clk_oe), 0);
        check("no_done_after_rst", done_cnt - d0, 0);

        // 0x00 after reset
        d0 = done_cnt;
        exp_err_q.push_back(1'b0);
        start_call(8'h00);
        check_inhibit();
        device(1'b1, 11, seen);
        check("z_line_literal", int'(seen), int'(11'b11000000000));
        wait_done(d0, 2000);
        repeat (20) @(negedge clk);

        // Second request during BITS is dropped
        d0 = done_cnt;
        exp_err_q.push_back(1'b0);
        fork
            begin
                start_call(8'h3C);
                check_inhibit();
                device(1'b1, 11, seen);
            end
            begin
                repeat (5700) @(posedge clk);
                check("busy_at_second_call", int'(busy), 1);
                #1 call = 1'b1;
                data = 8'hFF;
                @(posedge clk);
                #1 call = 1'b0;
            end
        join
        check("first_byte_kept", int'(seen), int'(model_frame(8'h3C)));
        wait_done(d0, 2000);
        repeat (300) @(negedge clk);
        check("single_done", done_cnt - d0, 1);
        check("queue_drained", exp_err_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
